// File: rtl/safe_lock_ctrl_pkg.sv
// Shared definitions for the safe combination-lock sequencer: FSM state encoding,
// digit field width and the helper that pulls one digit out of the packed code.
package safe_pkg;

  localparam int DIG_W      = 8;
  localparam int CODE_MAX_W = 256;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DIAL    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  // Digit i lives in bits [i*DIG_W +: DIG_W]; digit 0 sits in the LSBs.
  function automatic logic [DIG_W-1:0] code_digit(input logic [CODE_MAX_W-1:0] code,
                                                  input int idx);
    return code[idx*DIG_W +: DIG_W];
  endfunction

endpackage

// File: rtl/safe_lock_ctrl_if.sv
// Bus between the encoder decoder / buttons and the lock sequencer, plus the
// sequencer's status outputs toward the display and bolt driver.
interface safe_lock_ctrl_if #(
  parameter int POS_W = 6,
  parameter int IDX_W = 2
);

  logic             cnt_n;
  logic             up;
  logic             dirch;
  logic             confirm;
  logic             lock;
  logic [POS_W-1:0] pos;
  logic [IDX_W-1:0] digit_idx;
  logic             unlocked;
  logic             alarm;
  logic             fail;

  modport master (
    output cnt_n, up, dirch, confirm, lock,
    input  pos, digit_idx, unlocked, alarm, fail
  );

  modport slave (
    input  cnt_n, up, dirch, confirm, lock,
    output pos, digit_idx, unlocked, alarm, fail
  );

endinterface

// File: rtl/safe_lock_ctrl_pos_counter.sv
// Wrap-around dial position counter, 0..POS_MAX, moved one position per step.
module safe_pos_counter #(
  parameter int POS_MAX = 39,
  parameter int POS_W   = $clog2(POS_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             up,
  output logic [POS_W-1:0] pos
);

  localparam logic [POS_W-1:0] TOP = POS_W'(POS_MAX);

  logic [POS_W-1:0] pos_d;
  logic [POS_W-1:0] pos_q;

  // Next position with wrap at both ends.
  always_comb begin
    pos_d = pos_q;
    if (step) begin
      if (up) begin
        if (pos_q == TOP) begin
          pos_d = '0;
        end else begin
          pos_d = pos_q + POS_W'(1);
        end
      end else begin
        if (pos_q == '0) begin
          pos_d = TOP;
        end else begin
          pos_d = pos_q - POS_W'(1);
        end
      end
    end else begin
      pos_d = pos_q;
    end
  end

  // Position register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/safe_lock_ctrl.sv
// Combination-lock sequencer: captures a digit on every turn reversal, checks the
// entry on confirm and drives unlock / fail / alarm. SAFE_TIMEOUT_EN adds a dial inactivity timeout.
module safe_lock_ctrl
  import safe_pkg::*;
#(
  parameter int                    POS_MAX     = 39,
  parameter int                    NDIG        = 3,
  parameter logic [NDIG*DIG_W-1:0] CODE        = 24'h05190A,
  parameter int                    MAX_FAIL    = 3,
  parameter int                    LOCKOUT_CYC = 1000000,
  parameter int                    TIMEOUT_CYC = 5000000
) (
  input logic             clk,
  input logic             rst,
  safe_lock_ctrl_if.slave bus
);

  localparam int POS_W   = $clog2(POS_MAX + 1);
  localparam int IDX_W   = $clog2(NDIG);
  localparam int FC_W    = $clog2(MAX_FAIL + 1);
  localparam int TMR_MAX = (LOCKOUT_CYC > TIMEOUT_CYC) ? LOCKOUT_CYC : TIMEOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NDIG - 1);
  localparam logic [FC_W-1:0]       FAIL_LAST = FC_W'(MAX_FAIL - 1);
  localparam logic [TMR_W-1:0]      LOCK_LOAD = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [CODE_MAX_W-1:0] CODE_EXT  = CODE_MAX_W'(CODE);
`ifdef SAFE_TIMEOUT_EN
  localparam logic [TMR_W-1:0]      TMO_LOAD  = TMR_W'(TIMEOUT_CYC - 1);
`endif

  logic             step;
  logic             pos_match;
  logic [POS_W-1:0] pos_cur;

  state_t           state_d,    state_q;
  logic [IDX_W-1:0] idx_d,      idx_q;
  logic             err_d,      err_q;
  logic [FC_W-1:0]  fail_cnt_d, fail_cnt_q;
  logic [TMR_W-1:0] tmr_d,      tmr_q;
  logic             unlocked_d, unlocked_q;
  logic             alarm_d,    alarm_q;
  logic             fail_d,     fail_q;

  assign step = ~bus.cnt_n;

  safe_pos_counter #(
    .POS_MAX (POS_MAX),
    .POS_W   (POS_W)
  ) u_pos (
    .clk  (clk),
    .rst  (rst),
    .step (step),
    .up   (bus.up),
    .pos  (pos_cur)
  );

  // The registered position is the pre-step value, so a reversal coinciding with a step captures it.
  assign pos_match = (DIG_W'(pos_cur) == code_digit(CODE_EXT, int'(idx_q)));

  // Next-state, digit capture and output decode.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    fail_cnt_d = fail_cnt_q;
    tmr_d      = tmr_q;
    unlocked_d = 1'b0;
    alarm_d    = 1'b0;
    fail_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (step && bus.up) begin
          state_d = ST_DIAL;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
`ifdef SAFE_TIMEOUT_EN
        tmr_d = TMO_LOAD;
`endif
      end
      ST_DIAL: begin
        // confirm takes priority over a simultaneous reversal
        if (bus.confirm) begin
          if ((idx_q != LAST_IDX) || !pos_match) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          state_d = ST_CHECK;
        end else if (bus.dirch) begin
          if (idx_q != LAST_IDX) begin
            if (!pos_match) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
            idx_d = idx_q + IDX_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_DIAL;
        end
`ifdef SAFE_TIMEOUT_EN
        if (step || bus.dirch || bus.confirm) begin
          tmr_d = TMO_LOAD;
        end else if (tmr_q == '0) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
`endif
      end
      ST_CHECK: begin
        if (!err_q) begin
          state_d    = ST_OPEN;
          fail_cnt_d = '0;
          unlocked_d = 1'b1;
        end else begin
          fail_d     = 1'b1;
          fail_cnt_d = fail_cnt_q + FC_W'(1);
          if (fail_cnt_q == FAIL_LAST) begin
            state_d = ST_LOCKOUT;
            tmr_d   = LOCK_LOAD;
            alarm_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end
        end
      end
      ST_OPEN: begin
        if (bus.lock) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          state_d    = ST_OPEN;
          unlocked_d = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d    = ST_IDLE;
          idx_d      = '0;
          fail_cnt_d = '0;
        end else begin
          tmr_d   = tmr_q - TMR_W'(1);
          alarm_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        idx_d      = '0;
        err_d      = 1'b0;
        fail_cnt_d = '0;
        tmr_d      = '0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      err_q      <= 1'b0;
      fail_cnt_q <= '0;
      tmr_q      <= '0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      fail_cnt_q <= fail_cnt_d;
      tmr_q      <= tmr_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
      fail_q     <= fail_d;
    end
  end

  assign bus.pos       = pos_cur;
  assign bus.digit_idx = idx_q;
  assign bus.unlocked  = unlocked_q;
  assign bus.alarm     = alarm_q;
  assign bus.fail      = fail_q;

endmodule
